// File: rtl/axi_ws_pkg.sv
// Shared encodings, FSM state type and helper functions for the AXI3 write-channel burst slave.
package axi_ws_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } ws_state_e;

    // True when a beat of 1<<awsize bytes fits within a data_w-bit bus.
    function automatic logic size_ok(input logic [2:0] awsize, input int data_w);
        int bytes;
        bytes = 1 << awsize;
        return bytes <= (data_w / 8);
    endfunction

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and (with AXI_WS_WRAP_EN defined) WRAP bursts.
// Without AXI_WS_WRAP_EN the WRAP branch is absent and such bursts simply hold their address;
// the slave rejects them at AW time anyway.
module axi_burst_addr_gen
    import axi_ws_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] incr_addr;
`ifdef AXI_WS_WRAP_EN
    logic [ADDR_W-1:0] bound;
    logic [ADDR_W-1:0] mask;
`else
    logic unused_len;
    assign unused_len = ^len;
`endif

    // Pick the address of the following beat from the burst type.
    always_comb begin
        inc       = ONE << size;
        incr_addr = addr + inc;
`ifdef AXI_WS_WRAP_EN
        bound     = (ADDR_W'(len) + ONE) << size;
        mask      = bound - ONE;
`endif
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
`ifdef AXI_WS_WRAP_EN
            BURST_WRAP: next_addr = (addr & ~mask) | (incr_addr & mask);
`endif
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_write_slave_burst.sv
// AXI3 write-channel slave: accepts one burst at a time, issues one device write per good beat,
// checks WID/WLAST per beat and answers OKAY or SLVERR on B with the burst's ID.
// Optional feature: define AXI_WS_WRAP_EN to support WRAP bursts; otherwise WRAP returns SLVERR.
module axi_write_slave_burst
    import axi_ws_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ID_W-1:0]     WID,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    output logic                dev_wr_valid,
    output logic [ADDR_W-1:0]   dev_wr_addr,
    output logic [DATA_W-1:0]   dev_wr_data,
    output logic [DATA_W/8-1:0] dev_wr_strb,
    input  logic                dev_wr_ready
);

    ws_state_e         state_q;
    logic [ID_W-1:0]   awid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [3:0]        cnt_q;
    logic              err_q;
    logic              awready_q;
    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    logic              aw_err;
    logic              in_data;
    logic              beat;
    logic              last_beat;
    logic              beat_err;
    logic [ADDR_W-1:0] next_addr;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Once a burst is flagged bad, W is drained without touching the device.
    assign in_data      = (state_q == DATA);
    assign WREADY       = in_data && (err_q || dev_wr_ready);
    assign dev_wr_valid = in_data && !err_q && WVALID;
    assign dev_wr_addr  = addr_q;
    assign dev_wr_data  = WDATA;
    assign dev_wr_strb  = WSTRB;
    assign AWREADY      = awready_q;
    assign BVALID       = bvalid_q;
    assign BID          = bid_q;
    assign BRESP        = bresp_q;

    assign beat      = in_data && WVALID && WREADY;
    assign last_beat = (cnt_q == len_q);
    assign beat_err  = (WLAST != last_beat) || (WID != awid_q);

    // Classify the incoming AW request as unsupported before the burst starts.
    always_comb begin
        aw_err = 1'b0;
        if (!size_ok(AWSIZE, DATA_W)) begin
            aw_err = 1'b1;
        end
        if (AWBURST == 2'b11) begin
            aw_err = 1'b1;
        end
        if (AWBURST == BURST_WRAP) begin
`ifdef AXI_WS_WRAP_EN
            if (!wrap_len_ok(AWLEN)) begin
                aw_err = 1'b1;
            end
            if ((AWADDR & ((ADDR_W'(1) << AWSIZE) - ADDR_W'(1))) != '0) begin
                aw_err = 1'b1;
            end
`else
            aw_err = 1'b1;
`endif
        end
    end

    // Burst FSM: latch AW, step the beat address and count, then hold B until it is taken.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            awid_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    awready_q <= 1'b1;
                    if (AWVALID && awready_q) begin
                        awid_q    <= AWID;
                        addr_q    <= AWADDR;
                        len_q     <= AWLEN;
                        size_q    <= AWSIZE;
                        burst_q   <= AWBURST;
                        err_q     <= aw_err;
                        cnt_q     <= '0;
                        awready_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        addr_q <= next_addr;
                        cnt_q  <= cnt_q + 4'd1;
                        if (beat_err) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            state_q  <= RESP;
                            bvalid_q <= 1'b1;
                            bid_q    <= awid_q;
                            bresp_q  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave_burst.sv
// Directed self-checking bench for axi_write_slave_burst (DATA_W=32, ADDR_W=32, ID_W=4).
// The WRAP case adapts its expectations to AXI_WS_WRAP_EN.
module tb_axi_write_slave_burst;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic [ID_W-1:0]   AWID = '0;
    logic [ADDR_W-1:0] AWADDR = '0;
    logic [3:0]        AWLEN = '0;
    logic [2:0]        AWSIZE = '0;
    logic [1:0]        AWBURST = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [ID_W-1:0]   WID = '0;
    logic [DATA_W-1:0] WDATA = '0;
    logic [3:0]        WSTRB = '0;
    logic              WLAST = 1'b0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic              dev_wr_valid;
    logic [ADDR_W-1:0] dev_wr_addr;
    logic [DATA_W-1:0] dev_wr_data;
    logic [3:0]        dev_wr_strb;
    logic              dev_wr_ready = 1'b1;

    int vectorCount = 0;
    int miscompareCount = 0;

    axi_write_slave_burst #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .ID_W   (ID_W)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .AWID         (AWID),
        .AWADDR       (AWADDR),
        .AWLEN        (AWLEN),
        .AWSIZE       (AWSIZE),
        .AWBURST      (AWBURST),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WID          (WID),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WLAST        (WLAST),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .BID          (BID),
        .BRESP        (BRESP),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .dev_wr_valid (dev_wr_valid),
        .dev_wr_addr  (dev_wr_addr),
        .dev_wr_data  (dev_wr_data),
        .dev_wr_strb  (dev_wr_strb),
        .dev_wr_ready (dev_wr_ready)
    );

    always #5 ACLK = ~ACLK;

    // Single comparison point: counts every check and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Checks every output against its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_awready"}, 64'(AWREADY), 64'd0);
        checkOutput({tag, "_wready"}, 64'(WREADY), 64'd0);
        checkOutput({tag, "_bvalid"}, 64'(BVALID), 64'd0);
        checkOutput({tag, "_bresp"}, 64'(BRESP), 64'd0);
        checkOutput({tag, "_bid"}, 64'(BID), 64'd0);
        checkOutput({tag, "_devvalid"}, 64'(dev_wr_valid), 64'd0);
        checkOutput({tag, "_devaddr"}, 64'(dev_wr_addr), 64'd0);
    endtask

    // Holds reset for two edges, then releases it and checks the AWREADY rise timing.
    task automatic resetSequence(input string tag);
        ARESETn = 1'b0;
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        checkResetValues(tag);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput({tag, "_awready_hold"}, 64'(AWREADY), 64'd0);
        @(negedge ACLK);
        checkOutput({tag, "_awready_rise"}, 64'(AWREADY), 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    // Runs one complete burst: AW, all W beats, then B with optional BREADY delay.
    task automatic applyStimulus(
        input string                 name,
        input logic [ID_W-1:0]       id,
        input logic [31:0]           addr,
        input logic [3:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input int                    wlastBeat,
        input int                    badWidBeat,
        input int                    stallCycles,
        input logic [15:0]           devMask,
        input logic [3:0][31:0]      expAddr,
        input logic [1:0]            expResp,
        input int                    breadyDelay
    );
        int waitCycles;
        logic [31:0] beatData;
        logic [3:0] beatStrb;
        waitCycles = 0;
        @(negedge ACLK);
        while (AWREADY !== 1'b1 && waitCycles < 20) begin
            @(negedge ACLK);
            waitCycles++;
        end
        checkOutput({name, "_awready"}, 64'(AWREADY), 64'd1);
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = len;
        AWSIZE  = size;
        AWBURST = burst;
        AWVALID = 1'b1;
        @(posedge ACLK);
        #1 AWVALID = 1'b0;

        for (int b = 0; b <= int'(len); b++) begin
            beatData = 32'hC0DE_0000 | 32'(b);
            beatStrb = b[0] ? 4'h3 : 4'hC;
            WVALID = 1'b1;
            WDATA  = beatData;
            WSTRB  = beatStrb;
            WLAST  = (wlastBeat >= 0) ? (b == wlastBeat) : (b == int'(len));
            WID    = (b == badWidBeat) ? ~id : id;
            for (int s = 0; s < stallCycles; s++) begin
                dev_wr_ready = 1'b0;
                @(negedge ACLK);
                checkOutput({name, "_stall_wready"}, 64'(WREADY), 64'd0);
                checkOutput({name, "_stall_devvalid"}, 64'(dev_wr_valid), 64'd1);
                checkOutput({name, "_stall_addr"}, 64'(dev_wr_addr), 64'(expAddr[b[1:0]]));
                @(posedge ACLK);
                #1;
            end
            dev_wr_ready = (devMask != 16'h0);
            @(negedge ACLK);
            checkOutput({name, "_wready"}, 64'(WREADY), 64'd1);
            checkOutput({name, "_devvalid"}, 64'(dev_wr_valid), 64'(devMask[b]));
            if (devMask[b]) begin
                checkOutput({name, "_addr"}, 64'(dev_wr_addr), 64'(expAddr[b[1:0]]));
                checkOutput({name, "_data"}, 64'(dev_wr_data), 64'(beatData));
                checkOutput({name, "_strb"}, 64'(dev_wr_strb), 64'(beatStrb));
            end
            @(posedge ACLK);
            #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        dev_wr_ready = 1'b1;

        @(negedge ACLK);
        checkOutput({name, "_bvalid"}, 64'(BVALID), 64'd1);
        checkOutput({name, "_bid"}, 64'(BID), 64'(id));
        checkOutput({name, "_bresp"}, 64'(BRESP), 64'(expResp));
        checkOutput({name, "_resp_awready"}, 64'(AWREADY), 64'd0);
        for (int s = 0; s < breadyDelay; s++) begin
            WVALID = 1'b1;
            @(posedge ACLK);
            #1;
            @(negedge ACLK);
            checkOutput({name, "_bstall_bvalid"}, 64'(BVALID), 64'd1);
            checkOutput({name, "_bstall_bid"}, 64'(BID), 64'(id));
            checkOutput({name, "_bstall_bresp"}, 64'(BRESP), 64'(expResp));
            checkOutput({name, "_bstall_awready"}, 64'(AWREADY), 64'd0);
            checkOutput({name, "_bstall_wready"}, 64'(WREADY), 64'd0);
        end
        WVALID = 1'b0;
        BREADY = 1'b1;
        @(posedge ACLK);
        #1 BREADY = 1'b0;
        @(negedge ACLK);
        checkOutput({name, "_bdone_bvalid"}, 64'(BVALID), 64'd0);
        checkOutput({name, "_bdone_awready"}, 64'(AWREADY), 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    // Hard stop in case anything above stops making progress.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of bursts, protocol errors and resets.
    initial begin
        logic [3:0][31:0] addrs;

        resetSequence("rst");

        addrs = {32'h10C, 32'h108, 32'h104, 32'h100};
        applyStimulus("incr", 4'h5, 32'h100, 4'd3, 3'd2, 2'b01, -1, -1, 0, 16'h000F, addrs, 2'b00, 5);

        addrs = {32'h34, 32'h30, 32'h3C, 32'h38};
`ifdef AXI_WS_WRAP_EN
        applyStimulus("wrap", 4'h3, 32'h38, 4'd3, 3'd2, 2'b10, -1, -1, 0, 16'h000F, addrs, 2'b00, 0);
`else
        applyStimulus("wrap_off", 4'h3, 32'h38, 4'd3, 3'd2, 2'b10, -1, -1, 0, 16'h0000, addrs, 2'b10, 0);
`endif

        addrs = {32'h40, 32'h40, 32'h40, 32'h40};
        applyStimulus("fixed", 4'hA, 32'h40, 4'd2, 3'd2, 2'b00, -1, -1, 2, 16'h0007, addrs, 2'b00, 0);

        addrs = {32'h20C, 32'h208, 32'h204, 32'h200};
        applyStimulus("wlast_err", 4'h1, 32'h200, 4'd3, 3'd2, 2'b01, 1, -1, 0, 16'h0003, addrs, 2'b10, 0);

        addrs = {32'h30C, 32'h308, 32'h304, 32'h300};
        applyStimulus("wid_err", 4'h6, 32'h300, 4'd3, 3'd2, 2'b01, -1, 2, 0, 16'h0007, addrs, 2'b10, 0);

        addrs = {32'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus("size_err", 4'hE, 32'h0, 4'd1, 3'd3, 2'b01, -1, -1, 0, 16'h0000, addrs, 2'b10, 1);

        // Reset in the middle of a burst, after two beats have gone through.
        @(negedge ACLK);
        checkOutput("midrst_awready", 64'(AWREADY), 64'd1);
        AWID    = 4'h9;
        AWADDR  = 32'h500;
        AWLEN   = 4'd3;
        AWSIZE  = 3'd2;
        AWBURST = 2'b01;
        AWVALID = 1'b1;
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        WVALID = 1'b1;
        WID    = 4'h9;
        WLAST  = 1'b0;
        WDATA  = 32'h1234_5678;
        WSTRB  = 4'hF;
        dev_wr_ready = 1'b1;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        checkOutput("midrst_pre_addr", 64'(dev_wr_addr), 64'h508);
        checkOutput("midrst_pre_devvalid", 64'(dev_wr_valid), 64'd1);
        ARESETn = 1'b0;
        @(negedge ACLK);
        checkResetValues("midrst");
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        WVALID = 1'b0;
        @(negedge ACLK);
        checkOutput("midrst_rel_awready", 64'(AWREADY), 64'd0);
        checkOutput("midrst_rel_bvalid", 64'(BVALID), 64'd0);
        @(negedge ACLK);
        checkOutput("midrst_back_awready", 64'(AWREADY), 64'd1);
        checkOutput("midrst_back_bvalid", 64'(BVALID), 64'd0);
        @(posedge ACLK);
        #1;

        addrs = {32'h60C, 32'h608, 32'h604, 32'h600};
        applyStimulus("recover", 4'h2, 32'h600, 4'd3, 3'd2, 2'b01, -1, -1, 0, 16'h000F, addrs, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
